// File: rtl/bpsk_pwm_scheduler.sv
// BPSK amplitude scheduler for the PWM stage.
// Expands each accepted data bit into SAMPLES_PER_SYMBOL carrier samples, one per PWM
// frame, and changes the amplitude only on frame boundaries.
module bpsk_pwm_scheduler #(
    parameter int FRAME_LEN          = 16,
    parameter int SAMPLES_PER_SYMBOL = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        sym_valid,
    input  logic        sym_bit,
    output logic        sym_ready,
    output logic [7:0]  amp,          // two's-complement sample
    output logic        frame_strobe,
    output logic        busy,
    output logic        underrun,
    output logic [15:0] sym_count
);

    localparam int FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int SW = (SAMPLES_PER_SYMBOL > 1) ? $clog2(SAMPLES_PER_SYMBOL) : 1;
    localparam logic [FW-1:0] FRAME_LAST  = FW'(FRAME_LEN - 1);
    localparam logic [SW-1:0] SAMPLE_LAST = SW'(SAMPLES_PER_SYMBOL - 1);

    localparam logic ST_IDLE   = 1'b0;
    localparam logic ST_ACTIVE = 1'b1;

    // Quarter-wave symmetric table: magnitude 117 where exactly one of idx[1:0] is set,
    // 49 otherwise; idx[2] selects the negative half. Bit 0 flips the sign.
    function automatic logic [7:0] carrier(input logic [2:0] idx, input logic bit_val);
        logic [7:0] mag;
        logic       neg;
        mag = (idx[0] ^ idx[1]) ? 8'd117 : 8'd49;
        neg = idx[2] ^ ~bit_val;
        return neg ? (8'd0 - mag) : mag;
    endfunction

    logic [FW-1:0] frame_cnt_q, frame_cnt_d;
    logic          state_q, state_d;
    logic          nxt_bit_q, nxt_bit_d;
    logic          nxt_full_q, nxt_full_d;
    logic          cur_bit_q, cur_bit_d;
    logic [SW-1:0] sample_cnt_q, sample_cnt_d;
    logic [2:0]    car_idx_q, car_idx_d;
    logic [7:0]    amp_q, amp_d;
    logic          underrun_q, underrun_d;
    logic [15:0]   sym_count_q, sym_count_d;

    logic       accept;
    logic       do_load;
    logic [2:0] load_idx;

    assign frame_strobe = (frame_cnt_q == FRAME_LAST);
    assign sym_ready    = ~reset & ~nxt_full_q;
    assign busy         = (state_q == ST_ACTIVE);
    assign amp          = amp_q;
    assign underrun     = underrun_q;
    assign sym_count    = sym_count_q;
    assign accept       = sym_valid & sym_ready;

    // Next-state: holding-register accept every cycle, everything else on frame boundaries.
    always_comb begin
        frame_cnt_d  = (frame_cnt_q == FRAME_LAST) ? '0 : frame_cnt_q + FW'(1);
        state_d      = state_q;
        nxt_bit_d    = nxt_bit_q;
        nxt_full_d   = nxt_full_q;
        cur_bit_d    = cur_bit_q;
        sample_cnt_d = sample_cnt_q;
        car_idx_d    = car_idx_q;
        amp_d        = amp_q;
        underrun_d   = 1'b0;
        sym_count_d  = sym_count_q;
        do_load      = 1'b0;
        load_idx     = 3'd0;

        if (accept) begin
            nxt_bit_d  = sym_bit;
            nxt_full_d = 1'b1;
        end

        if (frame_strobe) begin
            case (state_q)
                ST_IDLE: begin
                    if (nxt_full_q) begin
                        do_load  = 1'b1;
                        load_idx = 3'd0;
                    end
                end
                default: begin
                    if (sample_cnt_q != SAMPLE_LAST) begin
                        sample_cnt_d = sample_cnt_q + SW'(1);
                        car_idx_d    = car_idx_q + 3'd1;
                        amp_d        = carrier(car_idx_q + 3'd1, cur_bit_q);
                    end else if (nxt_full_q) begin
                        // Back-to-back symbols keep carrier phase continuous.
                        do_load  = 1'b1;
                        load_idx = car_idx_q + 3'd1;
                    end else begin
                        state_d    = ST_IDLE;
                        amp_d      = 8'd0;
                        underrun_d = 1'b1;
                    end
                end
            endcase
        end

        // Load only happens with nxt_full_q set, so it never collides with an accept.
        if (do_load) begin
            cur_bit_d    = nxt_bit_q;
            nxt_full_d   = 1'b0;
            sample_cnt_d = '0;
            car_idx_d    = load_idx;
            amp_d        = carrier(load_idx, nxt_bit_q);
            sym_count_d  = sym_count_q + 16'd1;
            state_d      = ST_ACTIVE;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            frame_cnt_q  <= '0;
            state_q      <= ST_IDLE;
            nxt_bit_q    <= 1'b0;
            nxt_full_q   <= 1'b0;
            cur_bit_q    <= 1'b0;
            sample_cnt_q <= '0;
            car_idx_q    <= 3'd0;
            amp_q        <= 8'd0;
            underrun_q   <= 1'b0;
            sym_count_q  <= 16'd0;
        end else begin
            frame_cnt_q  <= frame_cnt_d;
            state_q      <= state_d;
            nxt_bit_q    <= nxt_bit_d;
            nxt_full_q   <= nxt_full_d;
            cur_bit_q    <= cur_bit_d;
            sample_cnt_q <= sample_cnt_d;
            car_idx_q    <= car_idx_d;
            amp_q        <= amp_d;
            underrun_q   <= underrun_d;
            sym_count_q  <= sym_count_d;
        end
    end

endmodule

// File: tb/tb_bpsk_pwm_scheduler.sv
// Self-checking bench for bpsk_pwm_scheduler: directed scenarios with literal expectations
// plus randomized traffic, all checked every cycle against a behavioural model.
module tb_bpsk_pwm_scheduler;

    localparam int FL  = 16;
    localparam int SPS = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        sym_valid = 1'b0;
    logic        sym_bit = 1'b0;
    logic        sym_ready;
    logic [7:0]  amp;
    logic        frame_strobe;
    logic        busy;
    logic        underrun;
    logic [15:0] sym_count;

    bpsk_pwm_scheduler #(
        .FRAME_LEN          (FL),
        .SAMPLES_PER_SYMBOL (SPS)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .sym_valid    (sym_valid),
        .sym_bit      (sym_bit),
        .sym_ready    (sym_ready),
        .amp          (amp),
        .frame_strobe (frame_strobe),
        .busy         (busy),
        .underrun     (underrun),
        .sym_count    (sym_count)
    );

    initial forever #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a pending-bit queue, frames left in the current symbol and a
    // running carrier phase that only resets when starting from idle.
    int tbl[8] = '{49, 117, 117, 49, -49, -117, -117, -49};
    bit m_live = 0;
    int m_pos, m_left, m_phase, m_bit, m_amp, m_under, m_count;
    int m_pend[$];
    bit m_acc;

    initial forever begin
        @(posedge clock);
        if (reset) begin
            m_live = 1; m_pos = 0; m_left = 0; m_phase = 0; m_bit = 0;
            m_amp = 0; m_under = 0; m_count = 0;
            m_pend.delete();
        end else if (m_live) begin
            m_acc   = sym_valid && (m_pend.size() == 0);
            m_under = 0;
            if (m_pos == FL - 1) begin
                if (m_left > 1) begin
                    m_left--;
                    m_phase = (m_phase + 1) % 8;
                end else if (m_pend.size() > 0) begin
                    m_phase = (m_left == 1) ? (m_phase + 1) % 8 : 0;
                    m_bit   = m_pend.pop_front();
                    m_left  = SPS;
                    m_count = (m_count + 1) % 65536;
                end else if (m_left == 1) begin
                    m_left  = 0;
                    m_under = 1;
                end
                m_amp = (m_left > 0) ? (m_bit != 0 ? tbl[m_phase] : -tbl[m_phase]) : 0;
            end
            if (m_acc) m_pend.push_back(int'(sym_bit));
            m_pos = (m_pos + 1) % FL;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge clock);
        if (m_live) begin
            check("model_amp", int'($signed(amp)), m_amp);
            check("model_frame_strobe", int'(frame_strobe), int'(m_pos == FL - 1));
            check("model_busy", int'(busy), int'(m_left > 0));
            check("model_underrun", int'(underrun), m_under);
            check("model_sym_count", int'(sym_count), m_count);
            check("model_sym_ready", int'(sym_ready), int'(!reset && m_pend.size() == 0));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not complete, got timeout, expected finish");
        $fatal(1);
    end

    int cyc_n = 0;

    task automatic next_cycle();
        @(posedge clock);
        #1;
        cyc_n++;
    endtask

    task automatic at_cycle(input int t);
        while (cyc_n < t) next_cycle();
    endtask

    task automatic sample();
        @(negedge clock);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        sym_valid = 1'b0;
        repeat (n) next_cycle();
        reset = 1'b0;
        cyc_n = 0;
    endtask

    int exp1[8]  = '{49, 117, 117, 49, -49, -117, -117, -49};
    int exp2[16] = '{49, 117, 117, 49, -49, -117, -117, -49,
                     -49, -117, -117, -49, 49, 117, 117, 49};
    int acc_n;
    int dens;

    initial begin
        // Reset then idle.
        do_reset(3);
        for (int k = 0; k < 40; k++) begin
            at_cycle(k);
            sample();
            check("idle_amp", int'($signed(amp)), 0);
            check("idle_busy", int'(busy), 0);
            check("idle_strobe", int'(frame_strobe), int'(k == 15 || k == 31));
        end
        at_cycle(41);

        // Single bit 1 offered in cycle 2.
        do_reset(3);
        at_cycle(2);
        sym_valid = 1'b1; sym_bit = 1'b1;
        sample();
        check("single_accept_ready", int'(sym_ready), 1);
        at_cycle(3);
        sym_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            at_cycle(16 + 16 * k);
            sample();
            check("single_amp_first", int'($signed(amp)), exp1[k]);
            at_cycle(31 + 16 * k);
            sample();
            check("single_amp_held", int'($signed(amp)), exp1[k]);
        end
        at_cycle(144);
        sample();
        check("single_end_amp", int'($signed(amp)), 0);
        check("single_end_underrun", int'(underrun), 1);
        check("single_end_busy", int'(busy), 0);
        check("single_sym_count", int'(sym_count), 1);
        at_cycle(145);
        sample();
        check("single_underrun_pulse", int'(underrun), 0);
        at_cycle(146);

        // Acceptance in the strobe cycle waits for the following boundary.
        do_reset(3);
        at_cycle(15);
        sym_valid = 1'b1; sym_bit = 1'b1;
        at_cycle(16);
        sym_valid = 1'b0;
        at_cycle(31);
        sample();
        check("strobe_accept_c31", int'($signed(amp)), 0);
        at_cycle(32);
        sample();
        check("strobe_accept_c32", int'($signed(amp)), 49);
        at_cycle(160);
        sample();
        check("strobe_accept_underrun", int'(underrun), 1);
        at_cycle(162);

        // Back-to-back bits 1 then 0.
        do_reset(3);
        at_cycle(2);
        sym_valid = 1'b1; sym_bit = 1'b1;
        at_cycle(3);
        sym_valid = 1'b0;
        at_cycle(20);
        sym_valid = 1'b1; sym_bit = 1'b0;
        at_cycle(21);
        sym_valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            at_cycle(16 + 16 * k);
            sample();
            check("b2b_amp", int'($signed(amp)), exp2[k]);
            at_cycle(23 + 16 * k);
            sample();
            check("b2b_busy", int'(busy), 1);
        end
        at_cycle(272);
        sample();
        check("b2b_end_underrun", int'(underrun), 1);
        check("b2b_end_amp", int'($signed(amp)), 0);
        check("b2b_sym_count", int'(sym_count), 2);
        at_cycle(274);

        // Backpressure: valid held high for three bits.
        do_reset(3);
        at_cycle(2);
        sym_valid = 1'b1; sym_bit = 1'b1;
        acc_n = 0;
        for (int c = 2; c <= 400; c++) begin
            at_cycle(c);
            if (acc_n >= 3) sym_valid = 1'b0;
            sample();
            if (sym_valid && sym_ready) acc_n++;
            if (c == 3)   check("bp_ready_c3", int'(sym_ready), 0);
            if (c == 16)  check("bp_ready_c16", int'(sym_ready), 1);
            if (c == 100) check("bp_ready_c100", int'(sym_ready), 0);
            if (c == 144) check("bp_ready_c144", int'(sym_ready), 1);
            if (c == 144) check("bp_amp_c144", int'($signed(amp)), 49);
            if (c == 145) check("bp_ready_c145", int'(sym_ready), 0);
            if (c == 272) check("bp_amp_c272", int'($signed(amp)), 49);
            if (c == 400) begin
                check("bp_end_underrun", int'(underrun), 1);
                check("bp_sym_count", int'(sym_count), 3);
            end
        end
        check("bp_accepts", acc_n, 3);
        at_cycle(402);

        // Reset asserted mid-symbol with a held bit.
        do_reset(3);
        at_cycle(2);
        sym_valid = 1'b1; sym_bit = 1'b1;
        at_cycle(3);
        sym_valid = 1'b0;
        at_cycle(20);
        sym_valid = 1'b1; sym_bit = 1'b0;
        at_cycle(21);
        sym_valid = 1'b0;
        at_cycle(69);
        sample();
        check("mid_busy_before", int'(busy), 1);
        check("mid_ready_before", int'(sym_ready), 0);
        at_cycle(70);
        reset = 1'b1;
        sample();
        check("mid_amp_in_reset_cycle", int'($signed(amp)), 49);
        at_cycle(71);
        reset = 1'b0;
        sample();
        check("mid_amp_after", int'($signed(amp)), 0);
        check("mid_busy_after", int'(busy), 0);
        check("mid_underrun_after", int'(underrun), 0);
        check("mid_sym_count_after", int'(sym_count), 0);
        check("mid_ready_after", int'(sym_ready), 1);
        for (int c = 72; c < 250; c++) begin
            at_cycle(c);
            sample();
            check("mid_no_underrun", int'(underrun), 0);
        end
        at_cycle(251);

        // Randomized traffic with varying offer density and rare resets.
        for (int blk = 0; blk < 20; blk++) begin
            dens = int'($urandom_range(1, 8));
            for (int i = 0; i < 150; i++) begin
                next_cycle();
                sym_valid = ($urandom_range(0, 7) < dens);
                sym_bit   = 1'($urandom);
                reset     = ($urandom_range(0, 399) == 0);
            end
        end
        reset = 1'b0;
        sym_valid = 1'b0;
        repeat (300) next_cycle();
        sample();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/bpsk_pwm_scheduler.md
# bpsk_pwm_scheduler

Sequences the amplitude input of the PWM stage for the BPSK transmitter. Accepts one data bit per handshake, expands each bit into a fixed number of carrier samples from an 8-entry sine table, sign-flipped for bit 0. Presents one signed 8-bit sample per PWM frame, changing only at frame boundaries so the PWM never sees a mid-frame amplitude change. Sits between the symbol source and the PWM modulator and owns frame alignment for both.

## Interface
- FRAME_LEN, 16: clocks per PWM frame; must match the PWM phase period; ≥2.
- SAMPLES_PER_SYMBOL, 8: PWM frames (carrier samples) per data bit; ≥1.
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- sym_valid  in  1  source offers sym_bit.
- sym_bit  in  1  data bit; 1 → carrier as tabled, 0 → negated carrier.
- sym_ready  out  1  = ~reset & ~nxt_full (combinational from registers).
- amp  out  8 signed  sample to PWM; registered.
- frame_strobe  out  1  high in last cycle of each frame (frame_cnt == FRAME_LEN-1); combinational from frame_cnt.
- busy  out  1  high while state == ACTIVE.
- underrun  out  1  one-cycle pulse, registered.
- sym_count  out  16  symbols loaded since reset; wraps 0xFFFF→0.

## Operation
- Carrier table, index 0..7: 49, 117, 117, 49, -49, -117, -117, -49. Negation never overflows (no -128 entry).
- frame_cnt: free-running 0..FRAME_LEN-1 after reset, independent of state; wraps to 0.
- One-deep holding register (nxt_bit, nxt_full). Accept when sym_valid & sym_ready: nxt_bit ← sym_bit, nxt_full ← 1.
- All remaining updates occur only at the boundary edge (edge ending a frame_strobe cycle):
- IDLE: if nxt_full → load (cur_bit ← nxt_bit, nxt_full ← 0, sample_cnt ← 0, car_idx ← 0, amp ← signed table[0], sym_count++, state ← ACTIVE). Else amp stays 0.
- ACTIVE, sample_cnt < SPS-1: sample_cnt++, car_idx ← car_idx+1 mod 8, amp ← signed table[new car_idx].
- ACTIVE, sample_cnt == SPS-1, nxt_full: load as above but car_idx continues (+1 mod 8), no phase reset between back-to-back symbols.
- ACTIVE, sample_cnt == SPS-1, ~nxt_full: state ← IDLE, amp ← 0, underrun ← 1 for one cycle.
- Load uses the registered holding register only; a symbol accepted in a strobe cycle is not loaded at that boundary.
- Load and accept never coincide (sym_ready low when nxt_full).

## Timing
- Reset values: frame_cnt 0, amp 0, state IDLE, nxt_full 0, cur_bit 0, sample_cnt 0, car_idx 0, underrun 0, sym_count 0, busy 0; sym_ready 0 while reset high, 1 first cycle after.
- Reset mid-symbol: all of the above on the next edge; in-flight and held symbols discarded; no underrun pulse.
- Latency from IDLE: symbol accepted in cycle t appears on amp after the first strobe cycle strictly later than t; max FRAME_LEN+1 cycles, min 2.
- Each sample held exactly FRAME_LEN cycles; symbol lasts FRAME_LEN·SPS cycles.
- sym_ready re-asserts the cycle after a load; source has a full symbol period to refill with no gap.
- underrun asserts in the cycle amp returns to 0; busy falls on the same edge.

## Test plan
- Reset then idle: reset high 3 cycles, low 40 → amp 0, busy 0, underrun 0; frame_strobe at cycles 15 and 31 after reset release (cycle 0 = first low).
- Single bit 1 offered cycle 2 → accepted cycle 2; amp = 49,117,117,49,-49,-117,-117,-49 on cycles 16–31, 32–47, …, 128–143; amp 0 and underrun pulse at cycle 144; sym_count 1.
- Back-to-back bits 1,0 (second offered while first active) → 16 consecutive samples, no zero gap; second symbol = -49,-117,-117,-49,49,117,117,49; one underrun at end; sym_count 2.
- Backpressure: sym_valid held high with bits 1,1,1 → sym_ready low from acceptance of second until first load boundary of second symbol; no symbol dropped or duplicated; sym_count 3.
- Acceptance in strobe cycle (offer at cycle 15) → not loaded at cycle-15 boundary; amp first becomes 49 at cycle 32.
- Reset asserted mid-symbol (cycle 70) with nxt_full → next edge amp 0, busy 0, sym_ready 1 after release, no underrun, sym_count 0.
